// File: rtl/tlb_pkg.sv
// Shared TLB definitions: opcode encoding, entry layout constants and the
// sequencer state type used by tlb_ctrl.
package tlb_pkg;

  typedef enum logic [1:0] {
    OP_TLBR  = 2'b00,
    OP_TLBWI = 2'b01,
    OP_TLBWR = 2'b10,
    OP_TLBP  = 2'b11
  } tlb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } tlb_state_e;

  localparam int TLB_ENTRY_W    = 86;
  localparam int TLB_VPN2_HI    = 70;
  localparam int TLB_VPN2_LO    = 52;
  localparam int TLB_P_MISS_BIT = 31;

  function automatic logic is_write(input tlb_op_e op);
    return (op == OP_TLBWI) || (op == OP_TLBWR);
  endfunction

endpackage

// File: rtl/tlb_random.sv
// Random/Wired register pair for TLBWR victim selection.
// Random counts down from ENTRIES-1 to Wired, then wraps back to ENTRIES-1.
// A Wired write reloads Random to ENTRIES-1. If Wired >= ENTRIES-1 Random
// stays pinned at ENTRIES-1.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wired_we      Wired write strobe
//   wired_i       new Wired value
//   random_o      current Random
//   wired_o       current Wired
module tlb_random #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wired_we,
  input  logic [IDX_W-1:0] wired_i,
  output logic [IDX_W-1:0] random_o,
  output logic [IDX_W-1:0] wired_o
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(ENTRIES - 1);

  logic [IDX_W-1:0] random_q, wired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= TOP;
      wired_q  <= '0;
    end else if (wired_we) begin
      wired_q  <= wired_i;
      random_q <= TOP;
    end else if (wired_q >= TOP || random_q == wired_q) begin
      random_q <= TOP;
    end else begin
      random_q <= random_q - 1'b1;
    end
  end

  assign random_o = random_q;
  assign wired_o  = wired_q;

endmodule

// File: rtl/tlb_ctrl.sv
// TLB management sequencer (TLBR/TLBWI/TLBWR/TLBP).
// Accepts one op at a time (IDLE -> EXEC -> RESP), drives the TLB write and
// probe ports for the single EXEC cycle, captures read/probe results at the
// end of EXEC and reports them as a one-cycle resp_valid pulse.
// Build option: TLB_CTRL_RANDOM_EN enables the Random/Wired registers
// (tlb_random) and makes TLBWR write at Random; otherwise TLBWR acts as TLBWI,
// random_o is ENTRIES-1, wired_o is 0 and wired_we is ignored.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready/req_op      request handshake and opcode
//   entry_i, index_i                CP0 entry image and Index
//   wired_we, wired_i               Wired register write
//   tlb_we, tlb_config,
//   tlb_config_index, tlb_p         TLB write/probe port
//   tlb_p_res_i                     probe result (bit 31 miss)
//   tlb_rd_index, tlb_rd_entry_i    TLB read port
//   resp_valid/op/entry/index       completion pulse to CP0
//   random_o, wired_o, busy         status
module tlb_ctrl
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [TLB_ENTRY_W-1:0] entry_i,
  input  logic [IDX_W-1:0]       index_i,
  input  logic                   wired_we,
  input  logic [IDX_W-1:0]       wired_i,
  output logic                   tlb_we,
  output logic [TLB_ENTRY_W-1:0] tlb_config,
  output logic [IDX_W-1:0]       tlb_config_index,
  output logic                   tlb_p,
  input  logic [31:0]            tlb_p_res_i,
  output logic [IDX_W-1:0]       tlb_rd_index,
  input  logic [TLB_ENTRY_W-1:0] tlb_rd_entry_i,
  output logic                   resp_valid,
  output logic [1:0]             resp_op,
  output logic [TLB_ENTRY_W-1:0] resp_entry,
  output logic [31:0]            resp_index,
  output logic [IDX_W-1:0]       random_o,
  output logic [IDX_W-1:0]       wired_o,
  output logic                   busy
);

  tlb_state_e       state_q;
  tlb_op_e          op_q;
  logic [IDX_W-1:0] idx_q;
  tlb_op_e          req_op_e;
  logic [IDX_W-1:0] tgt_idx;

  assign req_op_e = tlb_op_e'(req_op);

`ifdef TLB_CTRL_RANDOM_EN
  tlb_random #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_random (
    .clk      (clk),
    .rst      (rst),
    .wired_we (wired_we),
    .wired_i  (wired_i),
    .random_o (random_o),
    .wired_o  (wired_o)
  );
  // random_o is the pre-edge value, so a coincident Wired write cannot
  // disturb the victim a TLBWR latches on the same edge.
  assign tgt_idx = (req_op_e == OP_TLBWR) ? random_o : index_i;
`else
  logic unused_wired;
  assign unused_wired = ^{wired_we, wired_i};
  assign random_o     = IDX_W'(ENTRIES - 1);
  assign wired_o      = '0;
  assign tgt_idx      = index_i;
`endif

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign tlb_rd_index = (state_q == ST_EXEC && op_q == OP_TLBR) ? idx_q : '0;

  // Port outputs are registered: loaded on the accept edge so they are valid
  // for the whole EXEC cycle, and cleared on the edge that leaves EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      op_q             <= OP_TLBR;
      idx_q            <= '0;
      tlb_we           <= 1'b0;
      tlb_p            <= 1'b0;
      tlb_config       <= '0;
      tlb_config_index <= '0;
      resp_valid       <= 1'b0;
      resp_op          <= 2'b00;
      resp_entry       <= '0;
      resp_index       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q             <= req_op_e;
            idx_q            <= tgt_idx;
            tlb_we           <= is_write(req_op_e);
            tlb_p            <= (req_op_e == OP_TLBP);
            tlb_config       <= (req_op_e == OP_TLBR) ? '0 : entry_i;
            tlb_config_index <= is_write(req_op_e) ? tgt_idx : '0;
            state_q          <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          tlb_we           <= 1'b0;
          tlb_p            <= 1'b0;
          tlb_config       <= '0;
          tlb_config_index <= '0;
          resp_valid       <= 1'b1;
          resp_op          <= op_q;
          resp_entry       <= (op_q == OP_TLBR) ? tlb_rd_entry_i : '0;
          resp_index       <= (op_q == OP_TLBP) ? tlb_p_res_i : '0;
          state_q          <= ST_RESP;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_op    <= 2'b00;
          resp_entry <= '0;
          resp_index <= '0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl; Random/Wired expectations follow the
// TLB_CTRL_RANDOM_EN build option.
module tb_tlb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [85:0] entry_i;
  logic [3:0]  index_i;
  logic        wired_we;
  logic [3:0]  wired_i;
  logic        tlb_we;
  logic [85:0] tlb_config;
  logic [3:0]  tlb_config_index;
  logic        tlb_p;
  logic [31:0] tlb_p_res_i;
  logic [3:0]  tlb_rd_index;
  logic [85:0] tlb_rd_entry_i;
  logic        resp_valid;
  logic [1:0]  resp_op;
  logic [85:0] resp_entry;
  logic [31:0] resp_index;
  logic [3:0]  random_o;
  logic [3:0]  wired_o;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  tlb_ctrl #(.ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .entry_i(entry_i), .index_i(index_i),
    .wired_we(wired_we), .wired_i(wired_i), .tlb_we(tlb_we),
    .tlb_config(tlb_config), .tlb_config_index(tlb_config_index),
    .tlb_p(tlb_p), .tlb_p_res_i(tlb_p_res_i), .tlb_rd_index(tlb_rd_index),
    .tlb_rd_entry_i(tlb_rd_entry_i), .resp_valid(resp_valid),
    .resp_op(resp_op), .resp_entry(resp_entry), .resp_index(resp_index),
    .random_o(random_o), .wired_o(wired_o), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_rnd;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; entry_i = '0; index_i = '0;
    wired_we = 1'b0; wired_i = '0; tlb_p_res_i = '0; tlb_rd_entry_i = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_ready got ready=%b busy=%b want 1/0", req_ready, busy); n_err++; end
    n_cmp++; if (tlb_we !== 1'b0 || tlb_p !== 1'b0 || resp_valid !== 1'b0) begin
      $display("FAIL reset_strobes got we=%b p=%b rv=%b want 0", tlb_we, tlb_p, resp_valid); n_err++; end
    n_cmp++; if (tlb_config !== '0 || tlb_config_index !== '0 || tlb_rd_index !== '0 ||
                 resp_entry !== '0 || resp_index !== '0 || resp_op !== 2'b00) begin
      $display("FAIL reset_data got nonzero data outputs"); n_err++; end
    n_cmp++; if (random_o !== 4'd15 || wired_o !== 4'd0) begin
      $display("FAIL reset_rand got random=%0d wired=%0d want 15/0", random_o, wired_o); n_err++; end
    exp_rnd = 4'd15;
    for (int i = 1; i <= 20; i++) begin
      tick();
`ifdef TLB_CTRL_RANDOM_EN
      exp_rnd = (i == 16) ? 4'd15 : ((i > 16) ? 4'(31 - i) : 4'(15 - i));
`endif
      n_cmp++; if (random_o !== exp_rnd || req_ready !== 1'b1 || tlb_we !== 1'b0) begin
        $display("FAIL idle_random cyc %0d got random=%0d ready=%b we=%b want %0d/1/0",
                 i, random_o, req_ready, tlb_we, exp_rnd); n_err++; end
    end
  endtask

  task automatic test_tlbwi();
    logic [85:0] e;
    e = 86'h3_DEAD_BEEF_0000_1234;
    req_valid = 1'b1; req_op = 2'b01; index_i = 4'd5; entry_i = e;
    n_cmp++; if (tlb_we !== 1'b0) begin
      $display("FAIL wi_pre_we got %b want 0", tlb_we); n_err++; end
    tick();
    req_valid = 1'b0; entry_i = '0; index_i = '0;
    n_cmp++; if (tlb_we !== 1'b1 || tlb_config_index !== 4'd5 || tlb_config !== e) begin
      $display("FAIL wi_exec got we=%b idx=%0d cfg=%h want 1/5/%h", tlb_we, tlb_config_index, tlb_config, e); n_err++; end
    n_cmp++; if (req_ready !== 1'b0 || busy !== 1'b1 || resp_valid !== 1'b0) begin
      $display("FAIL wi_exec_hs got ready=%b busy=%b rv=%b want 0/1/0", req_ready, busy, resp_valid); n_err++; end
    tick();
    n_cmp++; if (resp_valid !== 1'b1 || resp_op !== 2'b01 || resp_entry !== '0 || resp_index !== '0) begin
      $display("FAIL wi_resp got rv=%b op=%b entry=%h index=%h want 1/01/0/0", resp_valid, resp_op, resp_entry, resp_index); n_err++; end
    n_cmp++; if (tlb_we !== 1'b0 || tlb_config !== '0 || req_ready !== 1'b0) begin
      $display("FAIL wi_resp_port got we=%b cfg=%h ready=%b want 0/0/0", tlb_we, tlb_config, req_ready); n_err++; end
    tick();
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL wi_done got rv=%b ready=%b want 0/1", resp_valid, req_ready); n_err++; end
  endtask

  task automatic test_tlbp();
    logic [31:0] res [2];
    res[0] = 32'h0000_0005; res[1] = 32'h8000_0000;
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_op = 2'b11; entry_i = 86'h1_2345_6789_ABCD; index_i = 4'd0;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (tlb_p !== 1'b1 || tlb_we !== 1'b0 || tlb_config !== 86'h1_2345_6789_ABCD) begin
        $display("FAIL p_exec[%0d] got p=%b we=%b cfg=%h", k, tlb_p, tlb_we, tlb_config); n_err++; end
      tlb_p_res_i = res[k];
      tick();
      tlb_p_res_i = '0;
      n_cmp++; if (resp_valid !== 1'b1 || resp_op !== 2'b11 || resp_index !== res[k] || resp_entry !== '0) begin
        $display("FAIL p_resp[%0d] got rv=%b op=%b index=%h want 1/11/%h", k, resp_valid, resp_op, resp_index, res[k]); n_err++; end
      tick();
    end
  endtask

  task automatic test_tlbr();
    req_valid = 1'b1; req_op = 2'b00; index_i = 4'd9; entry_i = 86'h7;
    tick();
    req_valid = 1'b0; index_i = '0;
    n_cmp++; if (tlb_rd_index !== 4'd9 || tlb_we !== 1'b0 || tlb_p !== 1'b0) begin
      $display("FAIL r_exec got rd_index=%0d we=%b p=%b want 9/0/0", tlb_rd_index, tlb_we, tlb_p); n_err++; end
    tlb_rd_entry_i = 86'h155;
    tick();
    tlb_rd_entry_i = '0;
    n_cmp++; if (resp_valid !== 1'b1 || resp_op !== 2'b00 || resp_entry !== 86'h155 || resp_index !== '0) begin
      $display("FAIL r_resp got rv=%b op=%b entry=%h index=%h want 1/00/155/0", resp_valid, resp_op, resp_entry, resp_index); n_err++; end
    tick();
  endtask

  // req_valid held high: a new op is accepted every third edge.
  task automatic test_back_to_back();
    req_valid = 1'b1; req_op = 2'b01; index_i = 4'd3; entry_i = 86'hABC;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_cmp++; if (tlb_we !== (c == 1 || c == 4) || req_ready !== (c == 3 || c == 6) ||
                   resp_valid !== (c == 2 || c == 5)) begin
        $display("FAIL b2b cyc %0d got we=%b ready=%b rv=%b", c, tlb_we, req_ready, resp_valid); n_err++; end
    end
    req_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_wired_tlbwr();
    logic [3:0] exp_idx, exp_rnd, exp_wired;
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick(); tick();      // Random 12 with the option enabled
    req_valid = 1'b1; req_op = 2'b10; index_i = 4'd7; entry_i = 86'h5A5A;
    wired_we = 1'b1; wired_i = 4'd4;
    tick();
    req_valid = 1'b0; wired_we = 1'b0;
`ifdef TLB_CTRL_RANDOM_EN
    exp_idx = 4'd12; exp_wired = 4'd4;
`else
    exp_idx = 4'd7; exp_wired = 4'd0;
`endif
    n_cmp++; if (tlb_we !== 1'b1 || tlb_config_index !== exp_idx) begin
      $display("FAIL wr_index got we=%b idx=%0d want 1/%0d", tlb_we, tlb_config_index, exp_idx); n_err++; end
    n_cmp++; if (random_o !== 4'd15 || wired_o !== exp_wired) begin
      $display("FAIL wired_load got random=%0d wired=%0d want 15/%0d", random_o, wired_o, exp_wired); n_err++; end
    for (int i = 1; i <= 13; i++) begin
      tick();
      exp_rnd = 4'd15;
`ifdef TLB_CTRL_RANDOM_EN
      if (i <= 11) exp_rnd = 4'(15 - i);
      else if (i == 13) exp_rnd = 4'd14;
`endif
      n_cmp++; if (random_o !== exp_rnd) begin
        $display("FAIL wired_cycle step %0d got %0d want %0d", i, random_o, exp_rnd); n_err++; end
    end
    wired_we = 1'b1; wired_i = 4'd15;
    tick();
    wired_we = 1'b0;
`ifdef TLB_CTRL_RANDOM_EN
    exp_wired = 4'd15;
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (random_o !== 4'd15 || wired_o !== exp_wired) begin
        $display("FAIL wired_max step %0d got random=%0d wired=%0d want 15/%0d", i, random_o, wired_o, exp_wired); n_err++; end
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_op = 2'b01; index_i = 4'd2; entry_i = 86'h99;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (tlb_we !== 1'b1) begin
      $display("FAIL mid_exec_we got %b want 1", tlb_we); n_err++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (tlb_we !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL mid_reset got we=%b rv=%b ready=%b busy=%b want 0/0/1/0", tlb_we, resp_valid, req_ready, busy); n_err++; end
    tick();
    n_cmp++; if (resp_valid !== 1'b0 || tlb_we !== 1'b0 || random_o !== 4'd14 - 4'd0 * 4'd0 + (4'd0)) begin
`ifdef TLB_CTRL_RANDOM_EN
      $display("FAIL mid_after got rv=%b we=%b random=%0d want 0/0/14", resp_valid, tlb_we, random_o); n_err++;
`else
      if (resp_valid !== 1'b0 || tlb_we !== 1'b0 || random_o !== 4'd15) begin
        $display("FAIL mid_after got rv=%b we=%b random=%0d want 0/0/15", resp_valid, tlb_we, random_o); n_err++;
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_tlbwi();
    test_tlbp();
    test_tlbr();
    test_back_to_back();
    test_wired_tlbwr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
